// File: rtl/st_delimiter_pkg.sv
// Shared types for the Avalon-ST delimiter filter.
// Delimiter modes, frame states and CSR addresses.
package st_delimiter_pkg;

  typedef enum logic {
    DELIM_DISCARD  = 1'b0,
    DELIM_PASSTHRU = 1'b1
  } delim_mode_e;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } frame_state_e;

  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_COUNT  = 2'd1;
  localparam logic [1:0] CSR_LEVEL  = 2'd2;
  localparam logic [1:0] CSR_STATE  = 2'd3;

endpackage

// File: rtl/st_sync_fifo.sv
// Synchronous FIFO: push/pop, full/empty/level.
// pop_data shows the head entry, zero when empty.
module st_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/st_delimiter_filter.sv
// Avalon-ST packet delimiter filter with frame checker and CSRs.
// Ports: clock/reset_n, CSR read bus, ST sink (in_*), ST source (out_*).
module st_delimiter_filter
  import st_delimiter_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          DEPTH = 4,
  parameter delim_mode_e MODE  = DELIM_DISCARD
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       csr_address,
  input  logic             csr_read,
  output logic [7:0]       csr_readdata,
  output logic             in_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  frame_state_e state;
  frame_state_e nxt_state;
  logic         run;
  logic         accept;
  logic         delim;
  logic         push;
  logic         full;
  logic         empty;
  logic [AW:0]  level;
  logic         cnt_inc;
  logic         set_nested;
  logic         set_stray;
  logic         set_orphan;
  logic         clr;
  logic [7:0]   packet_count;
  logic         err_nested;
  logic         err_stray;
  logic         err_orphan;
  logic         last_sop;
  logic         last_eop;

  // run holds in_ready low through reset and rises one edge later
  assign in_ready  = run & ~full;
  assign accept    = in_valid & in_ready;
  assign delim     = in_sop | in_eop;
  assign out_valid = ~empty;
  assign clr       = csr_read & (csr_address == CSR_STATUS);

  assign push = accept & (delim ? (MODE == DELIM_PASSTHRU)
                                : (state == IN_PACKET));

  st_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // a sop always restarts framing as if from IDLE
  always_comb begin
    nxt_state  = state;
    cnt_inc    = 1'b0;
    set_nested = 1'b0;
    set_stray  = 1'b0;
    set_orphan = 1'b0;
    if (accept) begin
      unique case (1'b1)
        in_sop: begin
          set_nested = (state == IN_PACKET);
          nxt_state  = in_eop ? IDLE : IN_PACKET;
          cnt_inc    = in_eop;
        end
        (in_eop && !in_sop): begin
          if (state == IN_PACKET) begin
            nxt_state = IDLE;
            cnt_inc   = 1'b1;
          end else begin
            set_stray = 1'b1;
          end
        end
        default: set_orphan = (state == IDLE);
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run          <= 1'b0;
      state        <= IDLE;
      packet_count <= '0;
      err_nested   <= 1'b0;
      err_stray    <= 1'b0;
      err_orphan   <= 1'b0;
      last_sop     <= 1'b0;
      last_eop     <= 1'b0;
    end else begin
      run          <= 1'b1;
      state        <= nxt_state;
      packet_count <= packet_count + 8'(cnt_inc);
      err_nested   <= set_nested | (err_nested & ~clr);
      err_stray    <= set_stray  | (err_stray  & ~clr);
      err_orphan   <= set_orphan | (err_orphan & ~clr);
      if (accept && delim) begin
        last_sop <= in_sop;
        last_eop <= in_eop;
      end
    end
  end

  always_comb begin
    csr_readdata = '0;
    unique case (csr_address)
      CSR_STATUS: csr_readdata = {3'b0, err_nested, err_stray,
                                  err_orphan, last_eop, last_sop};
      CSR_COUNT:  csr_readdata = packet_count;
      CSR_LEVEL:  csr_readdata = 8'(level);
      CSR_STATE:  csr_readdata = {7'b0, state == IN_PACKET};
      default:    csr_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_st_delimiter_filter.sv
// Scoreboard bench for st_delimiter_filter, DISCARD and PASSTHRU instances.
// Random and directed beats checked against a packet-level model.
module tb_st_delimiter_filter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [1:0] a0, a1;
  logic       r0, r1;
  logic [7:0] rd0, rd1;
  logic       ir0, ir1, iv0, iv1;
  logic [7:0] id0, id1;
  logic       sp0, sp1, ep0, ep1;
  logic       or0, or1, ov0, ov1;
  logic [7:0] od0, od1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_pkt[2];
  bit [7:0]   m_cnt[2];
  bit         m_nest[2], m_stray[2], m_orph[2];
  bit         m_ls[2], m_le[2];
  bit         done;
  bit         held0, held1;
  logic [7:0] hold0, hold1;

  st_delimiter_filter #(.WIDTH(8), .DEPTH(4)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .csr_address(a0), .csr_read(r0), .csr_readdata(rd0),
    .in_ready(ir0), .in_valid(iv0), .in_data(id0),
    .in_sop(sp0), .in_eop(ep0),
    .out_ready(or0), .out_valid(ov0), .out_data(od0)
  );

  st_delimiter_filter #(
    .WIDTH(8), .DEPTH(4),
    .MODE(st_delimiter_pkg::DELIM_PASSTHRU)
  ) dut1 (
    .clock(clock), .reset_n(reset_n),
    .csr_address(a1), .csr_read(r1), .csr_readdata(rd1),
    .in_ready(ir1), .in_valid(iv1), .in_data(id1),
    .in_sop(sp1), .in_eop(ep1),
    .out_ready(or1), .out_valid(ov1), .out_data(od1)
  );

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: packet framing rules applied beat by beat
  task automatic model(int s, bit sop, bit eop, logic [7:0] d);
    bit dl = sop | eop;
    if (dl ? (s == 1) : m_pkt[s]) begin
      if (s == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    if (sop) begin
      if (m_pkt[s]) m_nest[s] = 1;
      if (eop) begin m_cnt[s]++; m_pkt[s] = 0; end
      else m_pkt[s] = 1;
    end else if (eop) begin
      if (m_pkt[s]) begin m_cnt[s]++; m_pkt[s] = 0; end
      else m_stray[s] = 1;
    end else if (!m_pkt[s]) begin
      m_orph[s] = 1;
    end
    if (dl) begin m_ls[s] = sop; m_le[s] = eop; end
  endtask

  task automatic mclr(int s);
    m_nest[s] = 0; m_stray[s] = 0; m_orph[s] = 0;
  endtask

  task automatic mreset();
    for (int s = 0; s < 2; s++) begin
      mclr(s);
      m_pkt[s] = 0; m_cnt[s] = 0; m_ls[s] = 0; m_le[s] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  function automatic int stat(int s);
    return {m_nest[s], m_stray[s], m_orph[s], m_le[s], m_ls[s]};
  endfunction

  // Starts and returns 1 time unit after a rising edge
  task automatic send(int s, bit sop, bit eop, logic [7:0] d);
    bit got = 0;
    if (s == 0) begin iv0 = 1; sp0 = sop; ep0 = eop; id0 = d; end
    else        begin iv1 = 1; sp1 = sop; ep1 = eop; id1 = d; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if ((s == 0) ? ir0 : ir1) begin got = 1; break; end
    end
    if (got) model(s, sop, eop, d);
    else check("send_timeout", 0, 1);
    @(posedge clock); #1;
    if (s == 0) iv0 = 0; else iv1 = 0;
  endtask

  task automatic csr(int s, logic [1:0] addr, int exp, string name);
    if (s == 0) a0 = addr; else a1 = addr;
    #1;
    check(name, (s == 0) ? int'(rd0) : int'(rd1), exp);
    @(posedge clock); #1;
  endtask

  task automatic drain(int s);
    bit ok = 0;
    if (s == 0) or0 = 1; else or1 = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (s == 0 ? (q0.size() == 0 && !ov0)
                 : (q1.size() == 0 && !ov1)) begin
        ok = 1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  always @(negedge clock) begin
    if (!reset_n) held0 = 0;
    else begin
      if (held0) begin
        check("out0_hold_valid", ov0, 1);
        check("out0_hold_data", od0, hold0);
      end
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out0_extra: got 0x%0h expected no beat", od0);
        end else check("out0_data", od0, q0.pop_front());
      end
      held0 = ov0 && !or0;
      hold0 = od0;
    end
  end

  always @(negedge clock) begin
    if (!reset_n) held1 = 0;
    else begin
      if (held1) begin
        check("out1_hold_valid", ov1, 1);
        check("out1_hold_data", od1, hold1);
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_extra: got 0x%0h expected no beat", od1);
        end else check("out1_data", od1, q1.pop_front());
      end
      held1 = ov1 && !or1;
      hold1 = od1;
    end
  end

  initial begin
    reset_n = 0;
    {a0, a1, r0, r1, iv0, iv1} = '0;
    {id0, id1, sp0, sp1, ep0, ep1} = '0;
    or0 = 1; or1 = 1;
    mreset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", ov0, 0);
    check("rst_out_data", od0, 0);
    check("rst_in_ready0", ir0, 0);
    check("rst_in_ready1", ir1, 0);
    csr(0, 0, 0, "rst_status");
    csr(0, 1, 0, "rst_count");
    csr(0, 2, 0, "rst_level");
    csr(0, 3, 0, "rst_state");
    reset_n = 1;
    repeat (2) @(posedge clock);
    #1;
    check("run_in_ready0", ir0, 1);
    check("run_in_ready1", ir1, 1);

    // basic packet, discard and passthrough
    for (int s = 0; s < 2; s++) begin
      send(s, 1, 0, 8'hAA);
      send(s, 0, 0, 8'h01);
      send(s, 0, 0, 8'h02);
      send(s, 0, 1, 8'hBB);
      drain(s);
      csr(s, 1, 1, "pkt_count");
      csr(s, 0, 8'h02, "pkt_status");
    end

    // backpressure: four data beats fill the buffer
    or0 = 0;
    send(0, 1, 0, 8'h10);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 8'h20 + 8'(i));
    check("full_in_ready", ir0, 0);
    check("full_out_valid", ov0, 1);
    csr(0, 2, 4, "full_level");
    fork
      begin
        send(0, 0, 0, 8'h24);
        send(0, 0, 0, 8'h25);
        send(0, 0, 1, 8'h26);
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        or0 = 1;
      end
    join
    drain(0);
    csr(0, 1, 2, "bp_count");

    // framing errors from IDLE, then nested sop
    send(0, 0, 0, 8'h55);
    send(0, 0, 1, 8'h66);
    send(0, 1, 0, 8'h77);
    send(0, 1, 0, 8'h78);
    csr(0, 0, 8'h1D, "err_status");
    csr(0, 3, 1, "err_state");
    a0 = 0; r0 = 1;
    @(posedge clock); #1;
    r0 = 0;
    mclr(0);
    csr(0, 0, 8'h01, "err_cleared");
    send(0, 0, 1, 8'h79);
    // stray eop lands on the same edge as a status clear
    a0 = 0; r0 = 1;
    mclr(0);
    send(0, 0, 1, 8'h99);
    r0 = 0;
    csr(0, 0, 8'h0A, "set_over_clear");
    csr(0, 0, stat(0), "status_model");
    drain(0);

    // random traffic with random backpressure
    for (int s = 0; s < 2; s++) begin
      done = 0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            send(s, r < 15, r >= 10 && r < 25,
                 8'($urandom_range(0, 255)));
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clock); #1;
            if (s == 0) or0 = 1'($urandom_range(0, 1));
            else        or1 = 1'($urandom_range(0, 1));
          end
        end
      join
      drain(s);
      csr(s, 0, stat(s), "rnd_status");
      csr(s, 1, m_cnt[s], "rnd_count");
      csr(s, 2, 0, "rnd_level");
      csr(s, 3, m_pkt[s], "rnd_state");
    end

    // reset in the middle of a buffered packet
    or0 = 0;
    send(0, 1, 0, 8'h01);
    for (int i = 0; i < 3; i++) send(0, 0, 0, 8'h30 + 8'(i));
    csr(0, 2, 3, "mid_level");
    reset_n = 0;
    mreset();
    #1;
    check("mid_rst_out_valid", ov0, 0);
    check("mid_rst_out_data", od0, 0);
    check("mid_rst_in_ready", ir0, 0);
    csr(0, 2, 0, "mid_rst_level");
    csr(0, 3, 0, "mid_rst_state");
    csr(0, 1, 0, "mid_rst_count");
    reset_n = 1;
    repeat (2) @(posedge clock);
    #1;
    or0 = 1;
    send(0, 0, 0, 8'h77);
    csr(0, 0, 8'h04, "post_rst_orphan");
    csr(0, 3, 0, "post_rst_state");

    // 256 zero-length packets wrap the counter
    for (int i = 0; i < 256; i++) send(0, 1, 1, 8'(i));
    csr(0, 1, 0, "wrap_count");
    csr(0, 3, 0, "wrap_state");
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/st_delimiter_filter.md
ST_DELIMITER_FILTER -- requirements
Module: st_delimiter_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data beat width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, output buffer entries; power of two, >=2.
REQ-003 SHALL have parameter MODE, default DELIM_DISCARD, delimiter handling (DELIM_DISCARD or DELIM_PASSTHRU).
REQ-004 SHALL have ports: clock  in  1  sole clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: csr_address  in  2  CSR select; csr_read  in  1  read strobe; csr_readdata  out  8  CSR data.
REQ-006 SHALL have ports: in_ready  out  1; in_valid  in  1; in_data  in  WIDTH; in_sop  in  1; in_eop  in  1  (upstream Avalon-ST sink).
REQ-007 SHALL have ports: out_ready  in  1; out_valid  out  1; out_data  out  WIDTH  (downstream Avalon-ST source, no packet signals).

Function
REQ-008 Beat SHALL be accepted in a cycle where in_valid & in_ready; in_ready SHALL be ~full, no combinational path from out_ready.
REQ-009 Beat with in_sop|in_eop SHALL be a delimiter; otherwise a data beat.
REQ-010 Frame FSM SHALL have states IDLE and IN_PACKET, evaluated only on accepted beats.
REQ-011 IDLE: sop -> IN_PACKET; sop&eop -> stay IDLE, zero-length packet counted; eop alone -> stay IDLE, set err_stray; data beat -> stay IDLE, set err_orphan.
REQ-012 IN_PACKET: eop -> IDLE, packet counted; sop (with or without eop) -> set err_nested, then as REQ-011 from IDLE; data beat -> stay.
REQ-013 Data beats SHALL be pushed only in IN_PACKET; orphan data beats SHALL be dropped.
REQ-014 Delimiter beats SHALL be pushed iff MODE==DELIM_PASSTHRU, regardless of FSM state.
REQ-015 Pushed beat SHALL present on out_data/out_valid no earlier than the cycle after acceptance; order preserved.
REQ-016 out_valid SHALL equal ~empty; pop on out_valid & out_ready; out_data stable while out_valid & ~out_ready.
REQ-017 Simultaneous push and pop SHALL be allowed when not full and not empty; level unchanged.
REQ-018 packet_count SHALL be 8-bit, increment per counted packet, wrap 255->0.
REQ-019 last_sop/last_eop SHALL capture in_sop/in_eop of the most recent accepted delimiter beat.
REQ-020 csr_readdata SHALL be combinational from csr_address: 0 = {3'b0, err_nested, err_stray, err_orphan, last_eop, last_sop}; 1 = packet_count; 2 = buffer level zero-extended; 3 = {7'b0, state==IN_PACKET}.
REQ-021 csr_read with csr_address==0 SHALL clear the three error flags at that clock edge; a same-cycle set SHALL win over clear.
REQ-022 Error flags SHALL be sticky otherwise and SHALL NOT stall the data path.

Reset
REQ-023 reset_n low SHALL asynchronously force: FSM IDLE, buffer empty, out_valid 0, out_data 0, in_ready 0 during reset then 1, all flags and counters 0.
REQ-024 Reset mid-packet SHALL discard buffered beats; first post-reset beat evaluated from IDLE.

Structure
REQ-025 Package st_delimiter_pkg SHALL hold mode enum (DELIM_DISCARD, DELIM_PASSTHRU), frame-state enum, CSR address constants.
REQ-026 Buffer SHALL be sub-module st_sync_fifo (WIDTH, DEPTH, push/pop, full/empty/level); FSM, counters, CSR in top.

Verification
REQ-027 DISCARD, DEPTH=4, out_ready=1: sop(0xAA), 0x01, 0x02, eop(0xBB) -> out 0x01, 0x02 only; packet_count=1; addr0=0x02.
REQ-028 PASSTHRU: same stream -> out 0xAA, 0x01, 0x02, 0xBB; packet_count=1.
REQ-029 out_ready=0, DEPTH=4, 6 data beats in packet -> in_ready low after 4 accepted; release -> 6 beats out in order, none lost.
REQ-030 IDLE data 0x55, eop alone, then sop, sop -> 0x55 dropped; addr0 bits[4:2]=3'b111; csr_read addr0 -> reads back 0 next cycle.
REQ-031 256 sop&eop beats -> packet_count=0, FSM IDLE; reset_n low mid-packet with 3 buffered -> out_valid=0, level=0, addr3=0.
